// File: rtl/instruction_fetch_stage_pkg.sv
// instruction_fetch_stage_pkg: shared constants and types for the fetch stage
package instruction_fetch_stage_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [PC_W-1:0] NOP_WORD = 32'h0000_0000;
  typedef enum logic {FETCH, DISCARD} fetch_state_t;
endpackage

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer: one-entry slot parking a word that returns while decode is stalled
module fetch_hold_buffer
  import instruction_fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [PC_W-1:0] d_instr,
  input  logic [PC_W-1:0] d_pcplus4,
  output logic [PC_W-1:0] instr,
  output logic [PC_W-1:0] pcplus4,
  output logic            valid
);
  // clear beats load; payload only changes on load
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      instr   <= '0;
      pcplus4 <= '0;
      valid   <= 1'b0;
    end else if (clear) begin
      valid   <= 1'b0;
    end else if (load) begin
      instr   <= d_instr;
      pcplus4 <= d_pcplus4;
      valid   <= 1'b1;
    end
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC, variable-latency imem fetch, stall hold buffer, redirect, IF/ID register
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = instruction_fetch_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD = instruction_fetch_stage_pkg::NOP_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemRData,
  output logic [31:0] PC,
  output logic [31:0] IfIdInstr,
  output logic [31:0] IfIdPCPlus4,
  output logic        IfIdValid
);
  import instruction_fetch_stage_pkg::*;
  fetch_state_t state, state_nx;
  logic [31:0] pc_nx, pend_pc, pend_nx, pc_plus4, target, hold_instr, hold_pcplus4;
  logic hold_valid, in_flight, accept;
  assign pc_plus4  = PC + 32'd4;
  assign target    = {RedirectPC[31:2], 2'b00};
  assign in_flight = (state == DISCARD) | ~hold_valid;
  assign ImemReq   = ~Reset & in_flight;
  assign ImemAddr  = PC;
  assign accept    = (state == FETCH) & ImemReady & ~Redirect;
  fetch_hold_buffer u_hold (
    .clk       (Clk),
    .rst       (Reset),
    .load      (accept & Stall),
    .clear     (Redirect | (~Stall & hold_valid)),
    .d_instr   (ImemRData),
    .d_pcplus4 (pc_plus4),
    .instr     (hold_instr),
    .pcplus4   (hold_pcplus4),
    .valid     (hold_valid)
  );
  // a redirect with a fetch still outstanding parks its target so PC keeps addressing the in-flight word
  always_comb begin
    state_nx = state;
    pc_nx    = PC;
    pend_nx  = pend_pc;
    if (Redirect) begin
      if (ImemReady | ~in_flight) begin
        pc_nx    = target;
        state_nx = FETCH;
      end else begin
        pend_nx  = target;
        state_nx = DISCARD;
      end
    end else if (state == DISCARD) begin
      if (ImemReady) begin
        pc_nx    = pend_pc;
        state_nx = FETCH;
      end
    end else if (accept) begin
      pc_nx = pc_plus4;
    end
  end
  // fetch state, PC and parked redirect target
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state   <= FETCH;
      PC      <= RESET_PC;
      pend_pc <= '0;
    end else begin
      state   <= state_nx;
      PC      <= pc_nx;
      pend_pc <= pend_nx;
    end
  // IF/ID register: redirect/discard bubble, stall freeze, hold drain, fresh word, else bubble
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      IfIdInstr   <= NOP_WORD;
      IfIdPCPlus4 <= '0;
      IfIdValid   <= 1'b0;
    end else if (Redirect | (state == DISCARD)) begin
      IfIdInstr   <= NOP_WORD;
      IfIdPCPlus4 <= '0;
      IfIdValid   <= 1'b0;
    end else if (!Stall) begin
      IfIdInstr   <= hold_valid ? hold_instr : accept ? ImemRData : NOP_WORD;
      IfIdPCPlus4 <= hold_valid ? hold_pcplus4 : accept ? pc_plus4 : '0;
      IfIdValid   <= hold_valid | accept;
    end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: scoreboarded scenarios for the fetch stage
module tb_instruction_fetch_stage;
  typedef struct packed {logic [31:0] instr; logic [31:0] pc4; logic v;} ifid_t;
  logic Clk = 1'b0, Reset = 1'b1, Stall = 1'b0, Redirect = 1'b0, ImemReady = 1'b0;
  logic [31:0] RedirectPC = '0, ImemRData = '0;
  logic ImemReq, IfIdValid;
  logic [31:0] ImemAddr, PC, IfIdInstr, IfIdPCPlus4;
  ifid_t sb[$];
  ifid_t last;
  int checks = 0, errors = 0;

  always #5 Clk = ~Clk;

  instruction_fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady), .ImemRData(ImemRData),
    .PC(PC), .IfIdInstr(IfIdInstr), .IfIdPCPlus4(IfIdPCPlus4), .IfIdValid(IfIdValid)
  );

  function automatic ifid_t got();
    return {IfIdInstr, IfIdPCPlus4, IfIdValid};
  endfunction

  task automatic tick(input logic st, input logic rd, input logic [31:0] rpc,
                      input logic rdy, input logic [31:0] dat, input ifid_t e);
    Stall = st; Redirect = rd; RedirectPC = rpc; ImemReady = rdy; ImemRData = dat;
    sb.push_back(e);
    last = e;
    @(posedge Clk); #1;
    Stall = 1'b0; Redirect = 1'b0; ImemReady = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge Clk); #1;
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", PC, 32'h0); end
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", ImemReq); end
    checks++; if (got() !== ifid_t'('0)) begin errors++; $display("FAIL reset_ifid got %h exp 0", got()); end
    Reset = 1'b0; #1;
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin errors++; $display("FAIL post_reset_req got %b/%h exp 1/0", ImemReq, ImemAddr); end
  endtask

  task automatic test_stream();
    ifid_t e;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ImemAddr !== 32'(4*i)) begin errors++; $display("FAIL stream_addr[%0d] got %h exp %h", i, ImemAddr, 32'(4*i)); end
      tick(0, 0, 0, 1, 32'hA000_0000 + 32'(i), {32'hA000_0000 + 32'(i), 32'(4*i+4), 1'b1});
      e = sb.pop_front();
      checks++; if (got() !== e) begin errors++; $display("FAIL stream_ifid[%0d] got %h exp %h", i, got(), e); end
    end
  endtask

  task automatic test_wait();
    ifid_t e;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ImemAddr !== 32'd12 || ImemReq !== 1'b1) begin errors++; $display("FAIL wait_addr[%0d] got %h/%b exp c/1", i, ImemAddr, ImemReq); end
      tick(0, 0, 0, 0, 0, '0);
      e = sb.pop_front();
      checks++; if (got() !== e) begin errors++; $display("FAIL wait_bubble[%0d] got %h exp %h", i, got(), e); end
    end
    tick(0, 0, 0, 1, 32'hB00C_000C, {32'hB00C_000C, 32'd16, 1'b1});
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL wait_word got %h exp %h", got(), e); end
  endtask

  task automatic test_stall();
    ifid_t e;
    tick(1, 0, 0, 1, 32'hC010_0010, last);
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL stall_freeze0 got %h exp %h", got(), e); end
    checks++; if (ImemReq !== 1'b0 || PC !== 32'd20) begin errors++; $display("FAIL stall_hold0 got %b/%h exp 0/14", ImemReq, PC); end
    tick(1, 0, 0, 0, 0, last);
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL stall_freeze1 got %h exp %h", got(), e); end
    checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL stall_hold1 got %b exp 0", ImemReq); end
    tick(0, 0, 0, 0, 0, {32'hC010_0010, 32'd20, 1'b1});
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL stall_release got %h exp %h", got(), e); end
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'd20) begin errors++; $display("FAIL stall_next_addr got %b/%h exp 1/14", ImemReq, ImemAddr); end
  endtask

  task automatic test_discard();
    ifid_t e;
    tick(0, 1, 32'h80, 0, 0, '0);
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL disc_nop0 got %h exp %h", got(), e); end
    checks++; if (ImemAddr !== 32'd20 || ImemReq !== 1'b1) begin errors++; $display("FAIL disc_addr0 got %h/%b exp 14/1", ImemAddr, ImemReq); end
    tick(0, 1, 32'h41, 0, 0, '0);
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL disc_nop1 got %h exp %h", got(), e); end
    checks++; if (ImemAddr !== 32'd20) begin errors++; $display("FAIL disc_addr1 got %h exp 14", ImemAddr); end
    tick(0, 0, 0, 1, 32'hDEAD_BEEF, '0);
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL disc_drop got %h exp %h", got(), e); end
    checks++; if (ImemAddr !== 32'h40 || ImemReq !== 1'b1) begin errors++; $display("FAIL disc_target got %h/%b exp 40/1", ImemAddr, ImemReq); end
  endtask

  task automatic test_redirect_ready_stall();
    ifid_t e;
    tick(0, 0, 0, 1, 32'hD040_0040, {32'hD040_0040, 32'h44, 1'b1});
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL rr_word got %h exp %h", got(), e); end
    tick(0, 1, 32'h100, 1, 32'h1234_5678, '0);
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL rr_nop got %h exp %h", got(), e); end
    checks++; if (PC !== 32'h100) begin errors++; $display("FAIL rr_pc got %h exp 100", PC); end
    tick(1, 0, 0, 1, 32'hE100_0100, last);
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL rs_freeze got %h exp %h", got(), e); end
    checks++; if (ImemReq !== 1'b0 || PC !== 32'h104) begin errors++; $display("FAIL rs_hold got %b/%h exp 0/104", ImemReq, PC); end
    tick(1, 1, 32'h200, 0, 0, '0);
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL rs_nop got %h exp %h", got(), e); end
    checks++; if (PC !== 32'h200 || ImemReq !== 1'b1 || ImemAddr !== 32'h200) begin errors++; $display("FAIL rs_target got %h/%b/%h exp 200/1/200", PC, ImemReq, ImemAddr); end
    tick(0, 0, 0, 0, 0, '0);
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL rs_hold_cleared got %h exp %h", got(), e); end
  endtask

  task automatic test_wrap();
    ifid_t e;
    tick(0, 1, 32'hFFFF_FFFF, 1, 32'h0BAD_0BAD, '0);
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL wrap_nop got %h exp %h", got(), e); end
    checks++; if (PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target got %h exp fffffffc", PC); end
    tick(0, 0, 0, 1, 32'hF0F0_F0F0, {32'hF0F0_F0F0, 32'h0, 1'b1});
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL wrap_ifid got %h exp %h", got(), e); end
    checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", PC); end
    tick(0, 0, 0, 1, 32'h0, {32'h0, 32'h4, 1'b1});
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL zero_word got %h exp %h", got(), e); end
  endtask

  task automatic test_reset_discard();
    ifid_t e;
    tick(0, 1, 32'h300, 0, 0, '0);
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL rd_nop got %h exp %h", got(), e); end
    checks++; if (PC !== 32'h4 || ImemAddr !== 32'h4) begin errors++; $display("FAIL rd_inflight got %h/%h exp 4/4", PC, ImemAddr); end
    #2 Reset = 1'b1;
    #1;
    checks++; if (PC !== 32'h0 || ImemReq !== 1'b0 || ImemAddr !== 32'h0) begin errors++; $display("FAIL rd_async got %h/%b/%h exp 0/0/0", PC, ImemReq, ImemAddr); end
    checks++; if (got() !== ifid_t'('0)) begin errors++; $display("FAIL rd_ifid got %h exp 0", got()); end
    @(posedge Clk); #1;
    Reset = 1'b0;
    tick(0, 0, 0, 1, 32'h5EED_0000, {32'h5EED_0000, 32'h4, 1'b1});
    e = sb.pop_front();
    checks++; if (got() !== e) begin errors++; $display("FAIL rd_fetch_state got %h exp %h", got(), e); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_discard();
    test_redirect_ready_stall();
    test_wrap();
    test_reset_discard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
